// File: rtl/mux_word_serializer_if.sv
// Handshake bundle for the word serializer: upstream word channel, downstream bit channel,
// and the busy status flag.
interface mux_word_serializer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             up_vld;
   logic             up_rdy;
   logic [WIDTH-1:0] up_data;
   logic             down_vld;
   logic             down_rdy;
   logic             down_bit;
   logic             down_last;
   logic             busy;

   modport slave (
      input  up_vld,
      input  up_data,
      input  down_rdy,
      output up_rdy,
      output down_vld,
      output down_bit,
      output down_last,
      output busy
   );

   modport master (
      output up_vld,
      output up_data,
      output down_rdy,
      input  up_rdy,
      input  down_vld,
      input  down_bit,
      input  down_last,
      input  busy
   );
endinterface

// File: rtl/mux_word_serializer.sv
// Parallel-in / serial-out stage: captures a word over valid/ready and emits it one bit per
// beat through a WIDTH:1 mux, optionally inverted, with back-to-back word acceptance.
module mux_word_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          INVERT    = 1'b0
) (
   input logic                   clk,
   input logic                   rst_n,
   mux_word_serializer_if.slave  bus
);

   localparam int unsigned        IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IdxW-1:0]    LastIdx = IdxW'(WIDTH - 1);

   typedef enum logic {
      StIdle,
      StSend
   } state_e;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] w_word_nxt;
   logic [IdxW-1:0]  r_idx;
   logic [IdxW-1:0]  w_idx_nxt;
   logic [IdxW-1:0]  w_sel;
   logic             w_send;
   logic             w_last;
   logic             w_beat;
   logic             w_up_rdy;
   logic             w_accept;
   logic             w_raw_bit;

   assign w_send   = (r_state == StSend);
   assign w_last   = w_send && (r_idx == LastIdx);
   assign w_beat   = w_send && bus.down_rdy;
   // Ready is a function of state and down_rdy only, so no path from up_vld back to up_rdy.
   assign w_up_rdy = rst_n && (!w_send || (w_last && bus.down_rdy));
   assign w_accept = bus.up_vld && w_up_rdy;

   assign w_sel     = MSB_FIRST ? (LastIdx - r_idx) : r_idx;
   assign w_raw_bit = r_word[w_sel];

   assign bus.up_rdy    = w_up_rdy;
   assign bus.down_vld  = w_send;
   assign bus.down_bit  = w_send && (w_raw_bit ^ INVERT);
   assign bus.down_last = w_last;
   assign bus.busy      = w_send;

   always_comb begin
      w_state_nxt = r_state;
      w_word_nxt  = r_word;
      w_idx_nxt   = r_idx;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_nxt = StSend;
               w_word_nxt  = bus.up_data;
               w_idx_nxt   = '0;
            end
         end
         StSend: begin
            if (w_beat) begin
               if (!w_last) begin
                  w_idx_nxt = r_idx + IdxW'(1);
               end else if (w_accept) begin
                  // Next word loads in the same edge as the final beat: no idle bubble.
                  w_word_nxt = bus.up_data;
                  w_idx_nxt  = '0;
               end else begin
                  w_state_nxt = StIdle;
                  w_idx_nxt   = '0;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_word  <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_word  <= w_word_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

endmodule

// File: tb/tb_mux_word_serializer.sv
// Scoreboard bench: two serializer instances (MSB-first plain, LSB-first inverted); expected
// bits are queued when a word is offered and popped as beats are observed.
module tb_mux_word_serializer;

   localparam int unsigned W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic exp_bit_a[$];
   logic exp_last_a[$];
   logic exp_bit_b[$];
   logic exp_last_b[$];

   mux_word_serializer_if #(.WIDTH(W)) bus_a ();
   mux_word_serializer_if #(.WIDTH(W)) bus_b ();

   mux_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .INVERT(1'b0)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   mux_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .INVERT(1'b1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   always #5 clk = ~clk;

   // Offer a word on instance A and queue its expected MSB-first bit stream.
   task automatic load_a(input logic [W-1:0] d);
      @(negedge clk);
      bus_a.up_vld  = 1'b1;
      bus_a.up_data = d;
      for (int i = 0; i < W; i++) begin
         exp_bit_a.push_back(d[W-1-i]);
         exp_last_a.push_back(i == W - 1);
      end
   endtask

   // Offer a word on instance B and queue its expected LSB-first inverted bit stream.
   task automatic load_b(input logic [W-1:0] d);
      @(negedge clk);
      bus_b.up_vld  = 1'b1;
      bus_b.up_data = d;
      for (int i = 0; i < W; i++) begin
         exp_bit_b.push_back(~d[i]);
         exp_last_b.push_back(i == W - 1);
      end
   endtask

   task automatic test_reset();
      bus_a.up_vld = 1'b0; bus_a.up_data = '0; bus_a.down_rdy = 1'b1;
      bus_b.up_vld = 1'b0; bus_b.up_data = '0; bus_b.down_rdy = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks += 6;
         if (bus_a.down_vld !== 1'b0) begin
            n_errors++; $display("FAIL reset_down_vld: got %b expected 0", bus_a.down_vld);
         end
         if (bus_a.down_bit !== 1'b0) begin
            n_errors++; $display("FAIL reset_down_bit: got %b expected 0", bus_a.down_bit);
         end
         if (bus_a.down_last !== 1'b0) begin
            n_errors++; $display("FAIL reset_down_last: got %b expected 0", bus_a.down_last);
         end
         if (bus_a.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy);
         end
         if (bus_a.up_rdy !== 1'b1) begin
            n_errors++; $display("FAIL reset_up_rdy: got %b expected 1", bus_a.up_rdy);
         end
         if (bus_b.down_bit !== 1'b0) begin
            n_errors++; $display("FAIL reset_inv_down_bit: got %b expected 0", bus_b.down_bit);
         end
      end
   endtask

   task automatic test_msb_first();
      load_a(8'hA5);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         bus_a.up_vld = 1'b0;
         n_checks += 4;
         if (bus_a.down_vld !== 1'b1) begin
            n_errors++; $display("FAIL msb_vld beat %0d: got %b expected 1", i, bus_a.down_vld);
         end
         if (bus_a.down_bit !== exp_bit_a[0]) begin
            n_errors++;
            $display("FAIL msb_bit beat %0d: got %b expected %b", i, bus_a.down_bit, exp_bit_a[0]);
         end
         if (bus_a.down_last !== exp_last_a[0]) begin
            n_errors++;
            $display("FAIL msb_last beat %0d: got %b expected %b", i, bus_a.down_last,
                     exp_last_a[0]);
         end
         if (bus_a.up_rdy !== (i == W - 1)) begin
            n_errors++; $display("FAIL msb_up_rdy beat %0d: got %b", i, bus_a.up_rdy);
         end
         void'(exp_bit_a.pop_front());
         void'(exp_last_a.pop_front());
      end
      @(negedge clk);
      n_checks += 3;
      if (bus_a.down_vld !== 1'b0) begin
         n_errors++; $display("FAIL msb_idle_vld: got %b expected 0", bus_a.down_vld);
      end
      if (bus_a.busy !== 1'b0) begin
         n_errors++; $display("FAIL msb_idle_busy: got %b expected 0", bus_a.busy);
      end
      if (bus_a.up_rdy !== 1'b1) begin
         n_errors++; $display("FAIL msb_idle_up_rdy: got %b expected 1", bus_a.up_rdy);
      end
   endtask

   task automatic test_lsb_invert();
      load_b(8'h0F);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         bus_b.up_vld = 1'b0;
         n_checks += 3;
         if (bus_b.down_vld !== 1'b1) begin
            n_errors++; $display("FAIL inv_vld beat %0d: got %b expected 1", i, bus_b.down_vld);
         end
         if (bus_b.down_bit !== exp_bit_b[0]) begin
            n_errors++;
            $display("FAIL inv_bit beat %0d: got %b expected %b", i, bus_b.down_bit, exp_bit_b[0]);
         end
         if (bus_b.down_last !== exp_last_b[0]) begin
            n_errors++;
            $display("FAIL inv_last beat %0d: got %b expected %b", i, bus_b.down_last,
                     exp_last_b[0]);
         end
         void'(exp_bit_b.pop_front());
         void'(exp_last_b.pop_front());
      end
      @(negedge clk);
      n_checks += 2;
      if (bus_b.down_vld !== 1'b0) begin
         n_errors++; $display("FAIL inv_idle_vld: got %b expected 0", bus_b.down_vld);
      end
      if (bus_b.down_bit !== 1'b0) begin
         n_errors++; $display("FAIL inv_idle_bit_mask: got %b expected 0", bus_b.down_bit);
      end
   endtask

   task automatic test_back_to_back();
      load_a(8'hFF);
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus_a.up_data = 8'h00;
            for (int k = 0; k < W; k++) begin
               exp_bit_a.push_back(1'b0);
               exp_last_a.push_back(k == W - 1);
            end
         end
         if (i == W) bus_a.up_vld = 1'b0;
         n_checks += 4;
         if (bus_a.down_vld !== 1'b1) begin
            n_errors++; $display("FAIL b2b_vld beat %0d: got %b expected 1", i, bus_a.down_vld);
         end
         if (bus_a.down_bit !== exp_bit_a[0]) begin
            n_errors++;
            $display("FAIL b2b_bit beat %0d: got %b expected %b", i, bus_a.down_bit, exp_bit_a[0]);
         end
         if (bus_a.down_last !== exp_last_a[0]) begin
            n_errors++;
            $display("FAIL b2b_last beat %0d: got %b expected %b", i, bus_a.down_last,
                     exp_last_a[0]);
         end
         if (bus_a.up_rdy !== ((i == W - 1) || (i == 2 * W - 1))) begin
            n_errors++; $display("FAIL b2b_up_rdy beat %0d: got %b", i, bus_a.up_rdy);
         end
         void'(exp_bit_a.pop_front());
         void'(exp_last_a.pop_front());
      end
      @(negedge clk);
      n_checks++;
      if (bus_a.busy !== 1'b0) begin
         n_errors++; $display("FAIL b2b_idle_busy: got %b expected 0", bus_a.busy);
      end
   endtask

   task automatic test_stall();
      int beat;
      int stalls;
      beat   = 0;
      stalls = 0;
      load_a(8'h3C);
      for (int c = 0; c < 20 && exp_bit_a.size() > 0; c++) begin
         @(negedge clk);
         bus_a.up_vld = 1'b0;
         n_checks += 3;
         if (bus_a.down_vld !== 1'b1) begin
            n_errors++; $display("FAIL stall_vld cycle %0d: got %b expected 1", c, bus_a.down_vld);
         end
         if (bus_a.down_bit !== exp_bit_a[0]) begin
            n_errors++;
            $display("FAIL stall_bit cycle %0d: got %b expected %b", c, bus_a.down_bit,
                     exp_bit_a[0]);
         end
         if (bus_a.down_last !== exp_last_a[0]) begin
            n_errors++;
            $display("FAIL stall_last cycle %0d: got %b expected %b", c, bus_a.down_last,
                     exp_last_a[0]);
         end
         if (beat == 2 && stalls < 3) begin
            bus_a.down_rdy = 1'b0;
            stalls++;
         end else begin
            bus_a.down_rdy = 1'b1;
            beat++;
            void'(exp_bit_a.pop_front());
            void'(exp_last_a.pop_front());
         end
      end
      bus_a.down_rdy = 1'b1;
      n_checks++;
      if (exp_bit_a.size() != 0) begin
         n_errors++; $display("FAIL stall_timeout: %0d beats left, expected 0", exp_bit_a.size());
      end
      @(negedge clk);
      n_checks++;
      if (bus_a.busy !== 1'b0) begin
         n_errors++; $display("FAIL stall_idle_busy: got %b expected 0", bus_a.busy);
      end
   endtask

   task automatic test_reset_mid_word();
      load_a(8'hC3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus_a.up_vld = 1'b0;
         n_checks++;
         if (bus_a.down_bit !== exp_bit_a[0]) begin
            n_errors++;
            $display("FAIL midrst_bit beat %0d: got %b expected %b", i, bus_a.down_bit,
                     exp_bit_a[0]);
         end
         if (i < 4) begin
            void'(exp_bit_a.pop_front());
            void'(exp_last_a.pop_front());
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks += 3;
      if (bus_a.down_vld !== 1'b0) begin
         n_errors++; $display("FAIL midrst_async_vld: got %b expected 0", bus_a.down_vld);
      end
      if (bus_a.busy !== 1'b0) begin
         n_errors++; $display("FAIL midrst_async_busy: got %b expected 0", bus_a.busy);
      end
      if (bus_a.down_bit !== 1'b0) begin
         n_errors++; $display("FAIL midrst_async_bit: got %b expected 0", bus_a.down_bit);
      end
      exp_bit_a.delete();
      exp_last_a.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus_a.down_vld !== 1'b0) begin
         n_errors++; $display("FAIL midrst_after_vld: got %b expected 0", bus_a.down_vld);
      end
      load_a(8'h81);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         bus_a.up_vld = 1'b0;
         n_checks += 2;
         if (bus_a.down_bit !== exp_bit_a[0]) begin
            n_errors++;
            $display("FAIL post_rst_bit beat %0d: got %b expected %b", i, bus_a.down_bit,
                     exp_bit_a[0]);
         end
         if (bus_a.down_last !== exp_last_a[0]) begin
            n_errors++;
            $display("FAIL post_rst_last beat %0d: got %b expected %b", i, bus_a.down_last,
                     exp_last_a[0]);
         end
         void'(exp_bit_a.pop_front());
         void'(exp_last_a.pop_front());
      end
      @(negedge clk);
      n_checks++;
      if (bus_a.down_vld !== 1'b0) begin
         n_errors++; $display("FAIL post_rst_idle_vld: got %b expected 0", bus_a.down_vld);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_invert();
      test_back_to_back();
      test_stall();
      test_reset_mid_word();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
